quadrature_modulator: RTL and testbench

QUADRATURE_MODULATOR -- requirements
Module: quadrature_modulator

---
 rtl/quadrature_modulator.sv | 91 +++++++++
 tb/tb_quadrature_modulator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_modulator.sv
// Quadrature LO switch driver: a 4-clk LO whose phase is rotated in 90-degree steps by a
// stream of symbols, each held for a whole number of LO periods.
module quadrature_modulator (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] sym_data,
  input  logic [7:0] sym_len,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       out_i,
  output logic       out_q,
  output logic       busy,
  output logic       eob
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [1:0] p;
  logic [1:0] s_r;
  logic [8:0] n;
  logic       last_cycle;
  logic       accept;
  logic [1:0] e_run;

  assign last_cycle = (p == 2'd3) && (n == 9'd1);
  assign sym_ready  = enable && ((state == IDLE) || last_cycle);
  assign accept     = sym_valid && sym_ready;

  // Outputs are registered, so they are driven from the phase the counter advances into.
  always_comb begin
    e_run = p + 2'd1 + s_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      n     <= '0;
      s_r   <= '0;
      out_i <= 1'b0;
      out_q <= 1'b0;
      busy  <= 1'b0;
      eob   <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      p     <= '0;
      n     <= '0;
      out_i <= 1'b0;
      out_q <= 1'b0;
      busy  <= 1'b0;
      eob   <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      p     <= '0;
      s_r   <= sym_data;
      n     <= (sym_len == 8'd0) ? 9'd256 : {1'b0, sym_len};
      out_i <= ~sym_data[1];
      out_q <= ^sym_data;
      busy  <= 1'b1;
      eob   <= 1'b0;
    end else if (state == RUN) begin
      if (last_cycle) begin
        state <= IDLE;
        p     <= '0;
        n     <= '0;
        out_i <= 1'b0;
        out_q <= 1'b0;
        busy  <= 1'b0;
        eob   <= 1'b1;
      end else begin
        p <= p + 2'd1;
        if (p == 2'd3) begin
          n <= n - 9'd1;
        end
        out_i <= ~e_run[1];
        out_q <= ^e_run;
        busy  <= 1'b1;
        eob   <= 1'b0;
      end
    end else begin
      p     <= '0;
      out_i <= 1'b0;
      out_q <= 1'b0;
      busy  <= 1'b0;
      eob   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quadrature_modulator.sv
// Bench for quadrature_modulator: scenario tasks plus randomized traffic, checked against a
// cycle-within-symbol model of the LO phase rotation.
module tb_quadrature_modulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] sym_data = '0;
  logic [7:0] sym_len = '0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, out_i, out_q, busy, eob;

  int errors = 0;
  int checks = 0;

  // Model: whether a symbol is playing, the clk index inside it, its length in clks, its code.
  bit m_active = 1'b0;
  bit m_eob = 1'b0;
  int m_t = 0;
  int m_len_cyc = 0;
  int m_s = 0;

  quadrature_modulator dut (
    .clk(clk), .rst(rst), .enable(enable), .sym_data(sym_data), .sym_len(sym_len),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .out_i(out_i), .out_q(out_q),
    .busy(busy), .eob(eob)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_outs();
    int e;
    logic ei, eq;
    e  = (m_t + m_s) % 4;
    ei = m_active && (e < 2);
    eq = m_active && (e == 1 || e == 2);
    return {ei, eq, m_active, m_eob};
  endfunction

  function automatic logic exp_ready();
    return enable && (!m_active || (m_t == m_len_cyc - 1));
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit acc;
    acc = sym_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_eob = 1'b0; m_t = 0;
    end else if (!enable) begin
      m_active = 1'b0; m_eob = 1'b0; m_t = 0;
    end else if (acc) begin
      m_active  = 1'b1; m_eob = 1'b0; m_t = 0; m_s = int'(sym_data);
      m_len_cyc = 4 * ((sym_len == 8'd0) ? 256 : int'(sym_len));
    end else if (m_active) begin
      if (m_t == m_len_cyc - 1) begin
        m_active = 1'b0; m_eob = 1'b1; m_t = 0;
      end else begin
        m_t++; m_eob = 1'b0;
      end
    end else begin
      m_eob = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sym_valid = 1'b0;
    tick();
    checks++;
    if ({out_i, out_q, busy, eob} !== 4'b0000) begin
      errors++; $display("FAIL reset_outs got=%b exp=0000", {out_i, out_q, busy, eob});
    end
    checks++;
    if (sym_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_disabled got=%b exp=0", sym_ready);
    end
    rst = 1'b0; enable = 1'b1;
    #1;
    checks++;
    if (sym_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_release got=%b exp=1", sym_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] pat_i, pat_q;
    pat_i = 8'b11001100; pat_q = 8'b01100110;
    sym_data = 2'd0; sym_len = 8'd2; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({out_i, out_q, busy, eob} !== {pat_i[7-c], pat_q[7-c], 1'b1, 1'b0} ||
          {out_i, out_q, busy, eob} !== exp_outs()) begin
        errors++;
        $display("FAIL single_outs cyc=%0d got=%b exp=%b", c, {out_i, out_q, busy, eob}, exp_outs());
      end
      tick();
    end
    checks++;
    if ({out_i, out_q, busy, eob} !== 4'b0001) begin
      errors++; $display("FAIL single_eob got=%b exp=0001", {out_i, out_q, busy, eob});
    end
    tick();
    checks++;
    if (eob !== 1'b0) begin
      errors++; $display("FAIL single_eob_width got=%b exp=0", eob);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat_i;
    pat_i = 8'b11001001;
    sym_data = 2'd0; sym_len = 8'd1; sym_valid = 1'b1;
    tick();
    sym_data = 2'd1;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (out_i !== pat_i[8-c] || busy !== 1'b1 || eob !== 1'b0 ||
          {out_i, out_q, busy, eob} !== exp_outs()) begin
        errors++;
        $display("FAIL b2b_outs cyc=%0d got=%b exp=%b", c, {out_i, out_q, busy, eob}, exp_outs());
      end
      checks++;
      if (sym_ready !== exp_ready() || (c < 8 && sym_ready !== (c == 4))) begin
        errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, sym_ready, exp_ready());
      end
      tick();
      if (c == 4) sym_valid = 1'b0;
    end
    checks++;
    if ({busy, eob} !== 2'b01) begin
      errors++; $display("FAIL b2b_eob got=%b exp=01", {busy, eob});
    end
    tick();
  endtask

  task automatic test_len_zero();
    int cnt;
    cnt = 0;
    sym_data = 2'd2; sym_len = 8'd0; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    while (busy === 1'b1 && cnt < 1100) begin
      if (out_i !== ((cnt % 4) >= 2) || {out_i, out_q, busy, eob} !== exp_outs()) begin
        checks++; errors++;
        $display("FAIL len0_outs cyc=%0d got=%b exp=%b", cnt, {out_i, out_q, busy, eob}, exp_outs());
      end
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 1024) begin
      errors++; $display("FAIL len0_length got=%0d exp=1024", cnt);
    end
    checks++;
    if (eob !== 1'b1) begin
      errors++; $display("FAIL len0_eob got=%b exp=1", eob);
    end
    tick();
  endtask

  task automatic test_enable_abort();
    sym_data = 2'd3; sym_len = 8'd4; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    tick(); tick();
    enable = 1'b0;
    #1;
    checks++;
    if (sym_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready_drop got=%b exp=0", sym_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({out_i, out_q, busy, eob, sym_ready} !== 5'b00000 ||
          {out_i, out_q, busy, eob} !== exp_outs()) begin
        errors++;
        $display("FAIL abort_idle cyc=%0d got=%b exp=00000", c, {out_i, out_q, busy, eob, sym_ready});
      end
    end
    enable = 1'b1;
    #1;
    checks++;
    if (sym_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready_return got=%b exp=1", sym_ready);
    end
  endtask

  task automatic test_reset_midrun();
    sym_data = 2'd1; sym_len = 8'd3; sym_valid = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_drops_accept got=%b exp=0", busy);
    end
    rst = 1'b0;
    tick();
    sym_valid = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1; sym_valid = 1'b1;
    tick();
    checks++;
    if ({out_i, out_q, busy, eob} !== 4'b0000 || {out_i, out_q, busy, eob} !== exp_outs()) begin
      errors++; $display("FAIL rst_midrun got=%b exp=0000", {out_i, out_q, busy, eob});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sym_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready_after got=%b exp=1", sym_ready);
    end
    tick();
    sym_valid = 1'b0;
    checks++;
    if ({out_i, out_q, busy, eob} !== 4'b1110) begin
      errors++; $display("FAIL rst_restart_p0 got=%b exp=1110", {out_i, out_q, busy, eob});
    end
    while (m_active) tick();
    tick();
  endtask

  task automatic test_ignored_change();
    sym_data = 2'd1; sym_len = 8'd2; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      sym_data = 2'($urandom_range(0, 3));
      sym_len  = 8'($urandom_range(0, 255));
      checks++;
      if ({out_i, out_q, busy, eob} !== exp_outs()) begin
        errors++;
        $display("FAIL ignored_change cyc=%0d got=%b exp=%b", c, {out_i, out_q, busy, eob}, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 19) != 0);
      sym_valid = ($urandom_range(0, 2) != 0);
      sym_data  = 2'($urandom_range(0, 3));
      sym_len   = ($urandom_range(0, 49) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      #1;
      checks++;
      if (sym_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, sym_ready, exp_ready());
      end
      tick();
      checks++;
      if ({out_i, out_q, busy, eob} !== exp_outs()) begin
        errors++;
        $display("FAIL rand_outs cyc=%0d got=%b exp=%b", c, {out_i, out_q, busy, eob}, exp_outs());
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_len_zero();
    test_enable_abort();
    test_reset_midrun();
    test_ignored_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
